// File: rtl/fm_streamer_if.sv
// Feature-map streamer bus: memory read port plus the PE-facing pixel stream.
// Signal names keep the streamer's point of view (o_* driven by the streamer).
//   o_rd_en   : read strobe to the feature-map memory
//   o_rd_addr : row-major read address
//   i_rd_data : memory data, valid one cycle after o_rd_en
//   o_DataFM  : streamed pixel (PE i_DataFM)
//   o_en      : stream valid (PE i_en)
// Modports: master = streamer, slave = memory/PE side.
interface fm_streamer_if #(
    parameter int unsigned ADDR_W = 16
);
    localparam int unsigned DATA_W = 30;

    logic                     o_rd_en;
    logic [ADDR_W-1:0]        o_rd_addr;
    logic signed [DATA_W-1:0] i_rd_data;
    logic signed [DATA_W-1:0] o_DataFM;
    logic                     o_en;

    modport master (
        output o_rd_en, o_rd_addr, o_DataFM, o_en,
        input  i_rd_data
    );

    modport slave (
        input  o_rd_en, o_rd_addr, o_DataFM, o_en,
        output i_rd_data
    );
endinterface

// File: rtl/fm_streamer.sv
// fm_streamer: streams one (optionally zero-padded) feature map from memory to a
// PE as a gap-free run of S*S+FLUSH_CYCLES words, followed by a one-cycle o_done.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_start        : one-cycle request to stream a map (accepted only in IDLE)
//   bus (master)   : memory read port and PE stream (see fm_streamer_if)
//   o_busy         : streaming in progress
//   o_done         : one-cycle pulse the cycle after the last streamed word
// Configuration: define FM_STREAMER_PAD_EN to honour PADDING; otherwise PADDING
// is ignored and every generated pixel is read from memory.
module fm_streamer #(
    parameter int unsigned FM_SIZE      = 4,
    parameter int unsigned PADDING      = 0,
    parameter int unsigned FLUSH_CYCLES = 0,
    parameter int unsigned ADDR_W       = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    fm_streamer_if.master bus,
    output logic          o_busy,
    output logic          o_done
);

`ifdef FM_STREAMER_PAD_EN
    localparam int unsigned PAD = PADDING;
`else
    // Padding support compiled out: PADDING has no effect.
    localparam int unsigned PAD = PADDING * 0;
`endif
    localparam int unsigned S     = FM_SIZE + 2 * PAD;
    localparam int unsigned CNT_W = $clog2(S + 1);
    localparam int unsigned FL_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned DATA_W = 30;

    // Elaboration-time sanity checks on the map geometry.
    if (64'(FM_SIZE) * 64'(FM_SIZE) > (64'd1 << ADDR_W)) begin : g_addr_chk
        $error("fm_streamer: FM_SIZE*FM_SIZE exceeds the ADDR_W address space");
    end
    if (FM_SIZE == 0) begin : g_size_chk
        $error("fm_streamer: FM_SIZE must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   r_q, r_d, c_q, c_d;
    logic [FL_W-1:0]    fl_q, fl_d;
    logic               gen_q, gen_d;        // a word was generated this cycle
    logic               zero_q, zero_d;      // generated word must be forced to 0
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               busy_q, busy_d;
    logic               done_p_q, done_p_d;
    logic               en_q, zero_out_q, done_q;

    logic               gen_c, interior_c, last_c;
    logic [ADDR_W-1:0]  addr_c;

`ifdef FM_STREAMER_PAD_EN
    // Interior test on the padded grid.
    assign interior_c = (r_q >= CNT_W'(PAD)) && (r_q < CNT_W'(PAD + FM_SIZE)) &&
                        (c_q >= CNT_W'(PAD)) && (c_q < CNT_W'(PAD + FM_SIZE));
`else
    assign interior_c = 1'b1;
`endif

    assign last_c = (r_q == CNT_W'(S - 1)) && (c_q == CNT_W'(S - 1));
    assign addr_c = (ADDR_W'(r_q) - ADDR_W'(PAD)) * ADDR_W'(FM_SIZE)
                  + (ADDR_W'(c_q) - ADDR_W'(PAD));

    // Next-state: pixel (0,0) is generated on the same edge that accepts i_start,
    // so counters always point at the next pixel to generate.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        fl_d      = fl_q;
        gen_d     = 1'b0;
        zero_d    = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        done_p_d  = 1'b0;
        gen_c     = 1'b0;

        case (state_q)
            IDLE:   gen_c = i_start;
            STREAM: gen_c = 1'b1;
            FLUSH: begin
                gen_d  = 1'b1;
                zero_d = 1'b1;
                if (fl_q == FL_W'(FLUSH_CYCLES - 1)) begin
                    fl_d    = '0;
                    state_d = DONE;
                end else begin
                    fl_d = fl_q + FL_W'(1);
                end
            end
            DONE: begin
                state_d  = IDLE;
                done_p_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (gen_c) begin
            gen_d   = 1'b1;
            zero_d  = !interior_c;
            rd_en_d = interior_c;
            if (interior_c) begin
                rd_addr_d = addr_c;
            end
            if (last_c) begin
                r_d     = '0;
                c_d     = '0;
                state_d = (FLUSH_CYCLES > 0) ? FLUSH : DONE;
            end else begin
                state_d = STREAM;
                if (c_q == CNT_W'(S - 1)) begin
                    c_d = '0;
                    r_d = r_q + CNT_W'(1);
                end else begin
                    c_d = c_q + CNT_W'(1);
                end
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; en/zero/done are delayed one cycle to line up
    // with the memory read latency.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            r_q        <= '0;
            c_q        <= '0;
            fl_q       <= '0;
            gen_q      <= 1'b0;
            zero_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_p_q   <= 1'b0;
            en_q       <= 1'b0;
            zero_out_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            fl_q       <= fl_d;
            gen_q      <= gen_d;
            zero_q     <= zero_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            done_p_q   <= done_p_d;
            en_q       <= gen_q;
            zero_out_q <= zero_q;
            done_q     <= done_p_q;
        end
    end

    assign bus.o_rd_en   = rd_en_q;
    assign bus.o_rd_addr = rd_addr_q;
    assign bus.o_en      = en_q;
    // Memory data arrives in the output cycle, so the pixel path is a zero-insert mux.
    assign bus.o_DataFM  = (en_q && !zero_out_q) ? bus.i_rd_data : DATA_W'(0);
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_fm_streamer.sv
// Self-checking bench for fm_streamer: three instances (plain 4x4, 3x3 with
// PADDING=1, 2x2 with FLUSH_CYCLES=3) driven by directed and randomized maps and
// compared against a grid-level reference model.
module tb_fm_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] start;
    logic [2:0] rst_n;
    logic [2:0] en_w, rd_en_w, busy_w, done_w;
    logic [15:0]        addr_w [3];
    logic signed [29:0] data_w [3];

    logic signed [29:0] mem [3][16];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned FM = (g == 0) ? 4 : (g == 1) ? 3 : 2;
        localparam int unsigned PD = (g == 1) ? 1 : 0;
        localparam int unsigned FL = (g == 2) ? 3 : 0;

        fm_streamer_if #(.ADDR_W(16)) bus ();

        fm_streamer #(
            .FM_SIZE(FM), .PADDING(PD), .FLUSH_CYCLES(FL), .ADDR_W(16)
        ) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n[g]),
            .i_start (start[g]),
            .bus     (bus),
            .o_busy  (busy_w[g]),
            .o_done  (done_w[g])
        );

        // Memory: one-cycle read latency, garbage when not read.
        always @(posedge clk) begin
            if (bus.o_rd_en && (bus.o_rd_addr < 16'(FM * FM)))
                bus.i_rd_data <= mem[g][bus.o_rd_addr[3:0]];
            else
                bus.i_rd_data <= 30'($urandom);
        end

        assign en_w[g]    = bus.o_en;
        assign rd_en_w[g] = bus.o_rd_en;
        assign addr_w[g]  = bus.o_rd_addr;
        assign data_w[g]  = bus.o_DataFM;
    end

    // Stream monitor.
    logic signed [29:0] got [3][$];
    int en_cyc [3][$];
    int done_cyc [3][$];
    int rd_cnt [3];
    int zero_viol [3];

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (en_w[g] === 1'b1) begin
                got[g].push_back(data_w[g]);
                en_cyc[g].push_back(cyc);
            end else if (data_w[g] !== 30'sd0) begin
                zero_viol[g] = zero_viol[g] + 1;
            end
            if (done_w[g] === 1'b1) done_cyc[g].push_back(cyc);
            if (rd_en_w[g] === 1'b1) rd_cnt[g] = rd_cnt[g] + 1;
        end
    end

    int total = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int fm_of(input int g);
        return (g == 0) ? 4 : (g == 1) ? 3 : 2;
    endfunction

    function automatic int pad_of(input int g);
`ifdef FM_STREAMER_PAD_EN
        return (g == 1) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    function automatic int fl_of(input int g);
        return (g == 2) ? 3 : 0;
    endfunction

    function automatic int words_of(input int g);
        int s;
        s = fm_of(g) + 2 * pad_of(g);
        return s * s + fl_of(g);
    endfunction

    // mode 0: mem[k]=k, 1: mem[k]=k+1, 2: random
    task automatic fill(input int g, input int mode);
        for (int k = 0; k < 16; k++)
            mem[g][k] = (mode == 0) ? 30'(k) : (mode == 1) ? 30'(k + 1) : 30'($urandom);
    endtask

    task automatic clear_mon(input int g);
        got[g].delete();
        en_cyc[g].delete();
        done_cyc[g].delete();
        rd_cnt[g]    = 0;
        zero_viol[g] = 0;
    endtask

    // Stream 'maps' maps (second one started the cycle after DONE), optionally
    // re-pulsing i_start at relative cycle 'midpulse', then check everything.
    task automatic run_map(input int g, input int maps, input int midpulse, input string tag);
        int fm, p, sz, n, s0, limit, idx;
        logic signed [29:0] exp_w [$];
        fm = fm_of(g);
        p  = pad_of(g);
        sz = fm + 2 * p;
        n  = words_of(g);
        for (int r = 0; r < sz; r++)
            for (int c = 0; c < sz; c++)
                if (r >= p && r < p + fm && c >= p && c < p + fm)
                    exp_w.push_back(mem[g][(r - p) * fm + (c - p)]);
                else
                    exp_w.push_back(30'sd0);
        for (int i = 0; i < fl_of(g); i++) exp_w.push_back(30'sd0);

        @(posedge clk);
        clear_mon(g);
        @(negedge clk);
        s0 = cyc;
        start[g] = 1'b1;
        limit = maps * (n + 1) + 6;
        for (int rel = 1; rel <= limit; rel++) begin
            @(negedge clk);
            if (rel == 1) chk({tag, " busy_after_start"}, longint'(busy_w[g]), 1);
            start[g] = ((maps == 2) && (rel == n + 1)) || (rel == midpulse);
        end
        start[g] = 1'b0;

        chk({tag, " word_count"}, got[g].size(), maps * n);
        chk({tag, " done_count"}, done_cyc[g].size(), maps);
        for (int m = 0; m < maps; m++) begin
            for (int i = 0; i < n; i++) begin
                idx = m * n + i;
                if (idx < got[g].size()) begin
                    chk($sformatf("%s word[%0d]", tag, idx), longint'(got[g][idx]), longint'(exp_w[i]));
                    chk($sformatf("%s en_cycle[%0d]", tag, idx), en_cyc[g][idx] - s0, m * (n + 1) + 2 + i);
                end
            end
            if (m < done_cyc[g].size())
                chk($sformatf("%s done_cycle[%0d]", tag, m), done_cyc[g][m] - s0, m * (n + 1) + n + 2);
        end
        chk({tag, " rd_en_pulses"}, rd_cnt[g], maps * fm * fm);
        chk({tag, " zero_when_idle"}, zero_viol[g], 0);
        chk({tag, " busy_at_end"}, longint'(busy_w[g]), 0);
    endtask

    initial begin
        int g, maps, mid;
        start = '0;
        rst_n = '0;
        fill(0, 0);
        fill(1, 1);
        fill(2, 2);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_outputs[%0d]", i),
                longint'({en_w[i], rd_en_w[i], busy_w[i], done_w[i], addr_w[i], data_w[i]}), 0);
        rst_n = '1;

        // Plain 4x4 map with mem[k]=k.
        run_map(0, 1, 0, "map4");
        // 3x3 with PADDING=1 (padded only when the macro is defined), mem[k]=k+1.
        run_map(1, 1, 0, "pad3");
        // Flush words after a 2x2 map.
        run_map(2, 1, 0, "flush");
        // i_start re-pulsed mid-stream and during DONE.
        fill(0, 2);
        run_map(0, 1, 6, "restart_mid");
        run_map(1, 1, words_of(1), "start_in_done");
        // Back-to-back maps.
        run_map(0, 2, 0, "b2b4");
        fill(2, 2);
        run_map(2, 2, 0, "b2b_flush");

        // Reset at the 5th o_en cycle.
        fill(0, 2);
        @(posedge clk);
        clear_mon(0);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("rst_mid outputs",
            longint'({en_w[0], rd_en_w[0], busy_w[0], done_w[0], addr_w[0], data_w[0]}), 0);
        rst_n[0] = 1'b1;
        repeat (30) @(negedge clk);
        chk("rst_mid no_done", done_cyc[0].size(), 0);
        chk("rst_mid words_before_reset", got[0].size(), 5);
        run_map(0, 1, 0, "after_rst");

        // Randomized maps.
        for (int it = 0; it < 6; it++) begin
            g    = int'($urandom_range(0, 2));
            maps = int'($urandom_range(1, 2));
            mid  = int'($urandom_range(0, words_of(g)));
            fill(g, 2);
            run_map(g, maps, mid, $sformatf("rand%0d_g%0d", it, g));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
